adxl362_spi_slave: RTL and testbench

//  SPI slave front-end of the ADXL362 behavioural model; sits directly upstream of the register file.

---
 rtl/adxl362_spi_pkg.sv | 22 ++
 rtl/adxl362_spi_sync.sv | 34 +++
 rtl/adxl362_spi_slave.sv | 153 +++++++++++++++
 tb/tb_adxl362_spi_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_spi_pkg.sv
`default_nettype none
// ============================================================================
// adxl362_spi_pkg : ADXL362 SPI command codes and slave FSM state encoding
// Revision 1.0
// ============================================================================
package adxl362_spi_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;
   localparam logic [7:0] CMD_FIFO  = 8'h0D;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      RDATA  = 3'd3,
      WDATA  = 3'd4,
      IGNORE = 3'd5
   } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/adxl362_spi_sync.sv
`default_nettype none
// ============================================================================
// adxl362_spi_sync : multi-flop synchroniser with rise/fall strobes
// Revision 1.0
// ============================================================================
module adxl362_spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {STAGES{RESET_VAL}};
      end else begin
         sync <= {sync[STAGES-2:0], din};
      end
   end

   // Strobes compare the two oldest stages so they line up with 'level'.
   assign level = sync[STAGES-1];
   assign rise  = sync[STAGES-2] & ~sync[STAGES-1];
   assign fall  = ~sync[STAGES-2] & sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/adxl362_spi_slave.sv
`default_nettype none
// ============================================================================
// adxl362_spi_slave : ADXL362 SPI slave front-end (cmd/addr/burst data)
// Revision 1.0
// ============================================================================
module adxl362_spi_slave
   import adxl362_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [7:0]            data_write,
   input  logic [7:0]            data_read
);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic unused_sync;

   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk_sys), .rst_n(rst_n), .din(sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );
   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk_sys), .rst_n(rst_n), .din(cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   adxl362_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk_sys), .rst_n(rst_n), .din(mosi),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sync = sclk_level ^ mosi_rise ^ mosi_fall;

   spi_state_t state, state_next;
   logic [2:0] bit_cnt;
   logic [7:0] shift_in, shift_out, byte_in;
   logic       is_write, load_pend, inc_pend;
   logic       busy, sclk_en, sclk_fall_en, byte_done;

   // cs_level is still low in the cycle cs_rise fires, so a final edge counts.
   assign busy         = (state == CMD) || (state == ADDR) || (state == RDATA) || (state == WDATA);
   assign sclk_en      = sclk_rise & ~cs_level & busy;
   assign sclk_fall_en = sclk_fall & ~cs_level & busy;
   assign byte_in      = {shift_in[6:0], mosi_level};
   assign byte_done    = sclk_en && (bit_cnt == 3'd7);
   assign miso         = shift_out[7];

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (state != IDLE && cs_rise) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (cs_fall) state_next = CMD;
            CMD:     if (byte_done) begin
                        case (byte_in)
                           CMD_WRITE, CMD_READ: state_next = ADDR;
                           CMD_FIFO:            state_next = IGNORE;
                           default:             state_next = IGNORE;
                        endcase
                     end
            ADDR:    if (byte_done) state_next = is_write ? WDATA : RDATA;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= 3'd0;
         shift_in   <= 8'h00;
         shift_out  <= 8'h00;
         is_write   <= 1'b0;
         load_pend  <= 1'b0;
         inc_pend   <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         data_write <= 8'h00;
         miso_oe    <= 1'b0;
      end else begin
         write     <= 1'b0;
         load_pend <= 1'b0;
         inc_pend  <= 1'b0;

         if (state == IDLE && cs_fall) begin
            bit_cnt <= 3'd0;
         end
         if (sclk_en) begin
            shift_in <= byte_in;
            bit_cnt  <= bit_cnt + 3'd1;
         end

         if (byte_done) begin
            case (state)
               CMD:   is_write <= (byte_in == CMD_WRITE);
               ADDR:  begin
                         address   <= byte_in[ADDR_WIDTH-1:0];
                         load_pend <= ~is_write;
                      end
               RDATA: begin
                         address   <= address + 1'b1;
                         load_pend <= 1'b1;
                      end
               WDATA: begin
                         data_write <= byte_in;
                         write      <= 1'b1;
                         inc_pend   <= 1'b1;
                      end
               default: ;
            endcase
         end

         if (inc_pend) begin
            address <= address + 1'b1;
         end

         // The fall right after a byte's last rise (bit_cnt==0) must not
         // shift: the reload is what presents the next MSB.
         if (state == RDATA && load_pend) begin
            shift_out <= data_read;
            miso_oe   <= 1'b1;
         end else if (state == RDATA && sclk_fall_en && bit_cnt != 3'd0) begin
            shift_out <= {shift_out[6:0], 1'b0};
         end

         if (state != IDLE && cs_rise) begin
            shift_out <= 8'h00;
            miso_oe   <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_slave.sv
`default_nettype none
// ============================================================================
// tb_adxl362_spi_slave : scoreboard bench for the ADXL362 SPI slave
// Revision 1.0
// ============================================================================
module tb_adxl362_spi_slave;

   logic       clk_sys = 1'b0;
   logic       rst_n, sclk, cs_n, mosi;
   logic       miso, miso_oe, write;
   logic [5:0] address;
   logic [7:0] data_write, data_read;

   int tests = 0;
   int fails = 0;

   adxl362_spi_slave #(.SYNC_STAGES(2), .ADDR_WIDTH(6)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .write(write), .address(address),
      .data_write(data_write), .data_read(data_read)
   );

   always #5 clk_sys = ~clk_sys;

   // Register-file stand-in: DEVID block 0x00-0x03 is read-only.
   logic [7:0] mem [64];
   assign data_read = mem[address];

   logic [13:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic [7:0]  obs_byte;
   logic        obs_valid = 1'b0;
   logic        prev_write = 1'b0;
   logic        oe_seen = 1'b0;
   int          wr_count = 0;
   logic [7:0]  tx_buf [8];
   logic [7:0]  rx_hist [8];
   int          rx_n = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: pops the expected (address,data) pair per write pulse.
   always @(negedge clk_sys) begin
      if (miso_oe) oe_seen = 1'b1;
      if (write) begin
         wr_count++;
         chk("write_width", {15'd0, prev_write}, 16'd0);
         if (exp_wr.size() == 0) begin
            chk("unexpected_write", {2'b0, address, data_write}, 16'hFFFF);
         end else begin
            logic [13:0] e;
            e = exp_wr.pop_front();
            chk("write_addr", {10'd0, address}, {10'd0, e[13:8]});
            chk("write_data", {8'd0, data_write}, {8'd0, e[7:0]});
         end
         if (address >= 6'd4) mem[address] = data_write;
      end
      prev_write = write;
   end

   // Read monitor: pops the expected byte for each byte the master received.
   always @(posedge clk_sys) begin
      if (obs_valid) begin
         if (exp_rd.size() == 0) begin
            chk("unexpected_rd", {8'd0, obs_byte}, 16'hFFFF);
         end else begin
            chk("miso_byte", {8'd0, obs_byte}, {8'd0, exp_rd.pop_front()});
         end
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         repeat (5) @(negedge clk_sys);
         sclk  = 1'b1;
         rx[i] = miso;
         repeat (5) @(negedge clk_sys);
         sclk = 1'b0;
      end
   endtask

   task automatic post_rx(input logic [7:0] rx);
      rx_hist[rx_n] = rx;
      rx_n++;
      obs_byte  = rx;
      obs_valid = 1'b1;
      @(negedge clk_sys);
      obs_valid = 1'b0;
   endtask

   task automatic txn(input int nbytes, input int tail_bits, input bit is_read);
      logic [7:0] rx;
      rx_n = 0;
      cs_n = 1'b0;
      repeat (6) @(negedge clk_sys);
      for (int k = 0; k < nbytes; k++) begin
         spi_bits(tx_buf[k], 8, rx);
         if (is_read && k >= 2) post_rx(rx);
      end
      if (tail_bits > 0) spi_bits(tx_buf[nbytes], tail_bits, rx);
      repeat (6) @(negedge clk_sys);
      cs_n = 1'b1;
      repeat (8) @(negedge clk_sys);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_write"},      {15'd0, write},      16'd0);
      chk({tag, "_address"},    {10'd0, address},    16'd0);
      chk({tag, "_data_write"}, {8'd0, data_write},  16'd0);
      chk({tag, "_miso"},       {15'd0, miso},       16'd0);
      chk({tag, "_miso_oe"},    {15'd0, miso_oe},    16'd0);
   endtask

   task automatic read_one(input logic [5:0] a, input logic [7:0] e);
      exp_rd.push_back(e);
      tx_buf[0] = 8'h0B; tx_buf[1] = {2'b00, a}; tx_buf[2] = 8'h00;
      txn(3, 0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rx;
      int wr_before;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[0] = 8'hAD; mem[1] = 8'h1D; mem[2] = 8'hF2; mem[3] = 8'h01;
      for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk_sys);

      // DEVID burst read
      exp_rd.push_back(8'hAD); exp_rd.push_back(8'h1D);
      exp_rd.push_back(8'hF2); exp_rd.push_back(8'h01);
      tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00;
      txn(6, 0, 1'b1);

      // Burst write THRESH_ACT then read back
      exp_wr.push_back({6'h20, 8'h34}); exp_wr.push_back({6'h21, 8'h05});
      tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'h34; tx_buf[3] = 8'h05;
      txn(4, 0, 1'b0);
      exp_rd.push_back(8'h34); exp_rd.push_back(8'h05);
      tx_buf[0] = 8'h0B; tx_buf[1] = 8'h20; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(4, 0, 1'b1);
      chk("thresh_act", {5'd0, rx_hist[1][2:0], rx_hist[0]}, 16'h0534);

      // Address wrap 0x3F -> 0x00 on write and read
      exp_wr.push_back({6'h3F, 8'h77}); exp_wr.push_back({6'h00, 8'h88});
      tx_buf[0] = 8'h0A; tx_buf[1] = 8'h3F; tx_buf[2] = 8'h77; tx_buf[3] = 8'h88;
      txn(4, 0, 1'b0);
      exp_rd.push_back(8'h77); exp_rd.push_back(8'hAD);
      tx_buf[0] = 8'h0B; tx_buf[1] = 8'h3F; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(4, 0, 1'b1);

      // Abort mid-byte: no write to POWER_CTL
      wr_before = wr_count;
      tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h02;
      txn(2, 5, 1'b0);
      chk("abort_no_write", wr_count[15:0], wr_before[15:0]);
      chk("abort_idle_oe", {15'd0, miso_oe}, 16'd0);
      read_one(6'h2D, 8'h00);

      // Unknown / FIFO commands are ignored
      oe_seen = 1'b0;
      tx_buf[0] = 8'h0D; tx_buf[1] = 8'h0A; tx_buf[2] = 8'h0B; tx_buf[3] = 8'hFF;
      txn(4, 0, 1'b0);
      tx_buf[0] = 8'h55; tx_buf[1] = 8'h0A; tx_buf[2] = 8'h20; tx_buf[3] = 8'h99;
      txn(4, 0, 1'b0);
      chk("ignore_oe", {15'd0, oe_seen}, 16'd0);
      read_one(6'h00, 8'hAD);

      // Asynchronous reset during the second data byte of a burst write
      exp_wr.push_back({6'h2A, 8'h11});
      cs_n = 1'b0;
      repeat (6) @(negedge clk_sys);
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h2A, 8, rx);
      spi_bits(8'h11, 8, rx);
      spi_bits(8'h22, 3, rx);
      @(negedge clk_sys);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("midreset");
      sclk = 1'b0; cs_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      read_one(6'h2A, 8'h11);
      read_one(6'h02, 8'hF2);

      repeat (10) @(negedge clk_sys);
      chk("exp_wr_drained", exp_wr.size(), 16'd0);
      chk("exp_rd_drained", exp_rd.size(), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
